// File: rtl/mem_arbiter2.sv
// Two-master arbiter in front of a single-port synchronous RAM, one transaction per cycle.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin conflict resolution; default is fixed priority to port 0.

module mem_arbiter2 #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_rstrb,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wmask,
    output logic [31:0]       m0_rdata,
    output logic              m0_rbusy,
    output logic              m0_wbusy,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_rstrb,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wmask,
    output logic [31:0]       m1_rdata,
    output logic              m1_rbusy,
    output logic              m1_wbusy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rstrb,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_wmask,
    input  logic [31:0]       ram_rdata
);

    logic [ADDR_W-1:0] live_addr  [2];
    logic [31:0]       live_wdata [2];
    logic [3:0]        live_wmask [2];
    logic [1:0]        live_rstrb;
    logic [1:0]        live_wr;
    logic [1:0]        live;

    logic [1:0]        slot_valid;
    logic [1:0]        slot_write;
    logic [ADDR_W-1:0] slot_addr  [2];
    logic [31:0]       slot_wdata [2];
    logic [3:0]        slot_wmask [2];
    logic [31:0]       hold       [2];

    logic [1:0]        cand_valid;
    logic [1:0]        cand_write;
    logic [ADDR_W-1:0] cand_addr  [2];
    logic [31:0]       cand_wdata [2];
    logic [3:0]        cand_wmask [2];

    logic              issue;
    logic              winner;
    logic [1:0]        grant;
    logic              rd_pending;
    logic              owner;

    assign live_addr[0]  = m0_addr;
    assign live_wdata[0] = m0_wdata;
    assign live_wmask[0] = m0_wmask;
    assign live_rstrb[0] = m0_rstrb;
    assign live_addr[1]  = m1_addr;
    assign live_wdata[1] = m1_wdata;
    assign live_wmask[1] = m1_wmask;
    assign live_rstrb[1] = m1_rstrb;

    // Per-port request slot and read-data hold register; a parked request always goes before a new strobe
    for (genvar g = 0; g < 2; g++) begin : g_port
        logic              valid_q;
        logic              write_q;
        logic [ADDR_W-1:0] addr_q;
        logic [31:0]       wdata_q;
        logic [3:0]        wmask_q;
        logic [31:0]       hold_q;

        assign live_wr[g]    = |live_wmask[g];
        assign live[g]       = live_wr[g] | live_rstrb[g];

        assign slot_valid[g] = valid_q;
        assign slot_write[g] = write_q;
        assign slot_addr[g]  = addr_q;
        assign slot_wdata[g] = wdata_q;
        assign slot_wmask[g] = wmask_q;
        assign hold[g]       = hold_q;

        assign cand_valid[g] = valid_q | live[g];
        assign cand_write[g] = valid_q ? write_q : live_wr[g];
        assign cand_addr[g]  = valid_q ? addr_q  : live_addr[g];
        assign cand_wdata[g] = valid_q ? wdata_q : live_wdata[g];
        assign cand_wmask[g] = valid_q ? wmask_q : live_wmask[g];

        // A strobe arriving while the slot is occupied is dropped without touching the slot
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= 1'b0;
                write_q <= 1'b0;
                addr_q  <= '0;
                wdata_q <= '0;
                wmask_q <= '0;
            end else if (grant[g]) begin
                valid_q <= 1'b0;
            end else if (!valid_q && live[g]) begin
                valid_q <= 1'b1;
                write_q <= live_wr[g];
                addr_q  <= live_addr[g];
                wdata_q <= live_wdata[g];
                wmask_q <= live_wmask[g];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                hold_q <= '0;
            end else if (rd_pending && owner == 1'(g)) begin
                hold_q <= ram_rdata;
            end
        end
    end

    assign issue = |cand_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic contended;
    logic rr_favour;

    assign contended = &cand_valid;
    assign winner    = contended ? rr_favour : (cand_valid[1] & ~cand_valid[0]);

    // Only contended grants move the pointer, so an idle partner never loses its turn
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_favour <= 1'b0;
        end else if (contended) begin
            rr_favour <= ~winner;
        end
    end
`else
    assign winner = cand_valid[1] & ~cand_valid[0];
`endif

    assign grant[0] = issue & ~winner;
    assign grant[1] = issue & winner;

    // With nothing to issue, winner is 0 so the RAM address/data follow port 0
    assign ram_addr  = cand_addr[winner];
    assign ram_wdata = cand_wdata[winner];
    assign ram_rstrb = issue & ~cand_write[winner];
    assign ram_wmask = (issue & cand_write[winner]) ? cand_wmask[winner] : 4'b0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pending <= 1'b0;
            owner      <= 1'b0;
        end else begin
            rd_pending <= ram_rstrb;
            if (ram_rstrb) begin
                owner <= winner;
            end
        end
    end

    assign m0_rdata = (rd_pending && owner == 1'b0) ? ram_rdata : hold[0];
    assign m1_rdata = (rd_pending && owner == 1'b1) ? ram_rdata : hold[1];
    assign m0_rbusy = slot_valid[0] & ~slot_write[0];
    assign m1_rbusy = slot_valid[1] & ~slot_write[1];
    assign m0_wbusy = slot_valid[0] & slot_write[0];
    assign m1_wbusy = slot_valid[1] & slot_write[1];

endmodule

// File: doc/mem_arbiter2.md
# mem_arbiter2

Two-port arbiter sharing the single-port synchronous Memory block between the Processor (port 0) and a second bus master such as a DMA or firmware loader (port 1). Each master keeps the native mem_addr/mem_rstrb/mem_wmask bus and gains rbusy/wbusy stall flags. The arbiter issues at most one transaction per cycle to the RAM and returns read data to the owner one cycle after issue. It sits between the masters and the Memory instance inside the SOC, ahead of the isRAM/isIO decode.

## Interface
- ADDR_W, 32, address width of both master ports and the RAM port
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- mN_addr  in  ADDR_W  byte address, N = 0,1
- mN_rstrb  in  1  one-cycle read strobe
- mN_wdata  in  32  write data
- mN_wmask  in  4  byte write mask; nonzero for one cycle = write strobe
- mN_rdata  out  32  read data; valid in the cycle mN_rbusy is low after a read, held until the next read completes
- mN_rbusy  out  1  read accepted but not yet completed
- mN_wbusy  out  1  write accepted but not yet issued
- ram_addr  out  ADDR_W  to Memory mem_addr
- ram_rstrb  out  1  to Memory mem_rstrb
- ram_wdata  out  32  to Memory mem_wdata
- ram_wmask  out  4  to Memory mem_wmask
- ram_rdata  in  32  from Memory mem_rdata, valid the cycle after ram_rstrb

## Operation
- Per port: a request slot (valid, is_write, addr, wdata, wmask), a 32-bit rdata hold register.
- Live request in cycle T: the port's strobe (wmask != 0 or rstrb). If both are set, the request is a write and the read is dropped.
- A strobe on a port whose slot is already valid is ignored (protocol violation). The slot is not modified.
- Candidates for cycle T: the slot if valid, otherwise the live request. A slot always precedes a new strobe on the same port.
- Arbitration when both ports have a candidate: the winner is picked per the Configuration section. The loser's candidate is stored in or kept in its slot.
- Issue: drive ram_* from the winner. Non-winners drive ram_rstrb=0 and ram_wmask=0. The winner's slot clears at the next edge. A losing live strobe is captured into the slot at the next edge.
- Read issue: register owner (port id) and rd_pending=1. In cycle T+1, mOwner_rdata = ram_rdata (combinational pass-through) and the hold register captures ram_rdata. In every other cycle mN_rdata = hold register.
- A new issue can occur in the same cycle as read-data return. This gives full throughput of 1 transaction/cycle.
- Outputs when idle: ram_addr = m0_addr, ram_wdata = m0_wdata, strobes 0.

## Timing
- Reset values: all slots invalid; rd_pending=0; owner=0; rr pointer favours port 0; hold registers 0. As a result mN_rdata=0, mN_rbusy=0, mN_wbusy=0, ram_rstrb=0, ram_wmask=0.
- Uncontended read strobed at T: issued at T. mN_rbusy stays 0. Data appears on mN_rdata at T+1.
- Contended read strobed at T, issued at T+k: mN_rbusy=1 from T+1 through T+k, and 0 at T+k+1 with data valid.
- Uncontended write strobed at T: issued at T. mN_wbusy stays 0.
- Contended write: mN_wbusy=1 from T+1 until the cycle after issue.
- ram_* outputs are combinational from strobes and slots. No registered delay on issue.
- Reset asserted mid-operation: the next edge clears slots, rd_pending and busy flags. In-flight read data is discarded and not captured. Pending writes are dropped.
- Simultaneous read return for port A and new issue for port B: both proceed. A's rdata is unaffected.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: on conflict, the port not granted most recently wins. The pointer updates only on contended grants.
- Without the macro: fixed priority, port 0 always wins. Port 1 can starve. The pointer logic is not compiled.

## Test plan
- Reset then idle: all busy flags 0, mN_rdata=0, ram_rstrb=0, ram_wmask=0. Then m0 reads 0x10 holding 0xDEADBEEF: m0_rbusy stays 0 and m0_rdata=0xDEADBEEF at T+1.
- Same-cycle m0 write 0x20 (mask 1111, 0x11223344) and m1 read 0x20:
  - Fixed priority: the write issues at T, m1_rbusy=1 at T+1, m1 gets 0x11223344 at T+2.
  - Round-robin after a prior contended m0 grant: m1 wins and gets the old value.
- Round-robin fairness: both ports strobe reads every cycle after completion. Grants alternate 0,1,0,1. Without the macro, every contended grant goes to port 0.
- Byte write m1 mask 0100 data 0x00AB0000 at 0x30 (old 0xFFFFFFFF), then m0 read 0x30: m0_rdata = 0xFFABFFFF.
- m1 read pending behind m0 (m1_rbusy=1) and reset asserted: next cycle m1_rbusy=0, m1_rdata=0, no ram_rstrb for m1 afterward.
- m1 strobes a second write while m1_wbusy=1: the second write is never issued, and RAM keeps the first write's value.
